// File: rtl/tri_word_assembler_pkg.sv
// Shared definitions for the triangle record assembler.
//   WORD_W            : width of one deserialised word
//   TRI_WORDS_DEFAULT : default words per triangle record (3 vertices x {x,y,z})
//   tri_word_t        : one deserialised word
//   rec_width()       : bit width of a record holding a given number of words
package tri_word_assembler_pkg;

  localparam int unsigned WORD_W            = 16;
  localparam int unsigned TRI_WORDS_DEFAULT = 9;

  typedef logic [WORD_W-1:0] tri_word_t;

  function automatic int unsigned rec_width(input int unsigned words);
    return words * WORD_W;
  endfunction

endpackage

// File: rtl/tri_record_fifo.sv
// Record buffer for the triangle assembler.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   wr_en    : push wr_data; accepted when not full, or when full and a read happens this cycle
//   wr_data  : record to push
//   full     : occupancy equals Depth
//   rd_en    : pop the head (ignored when empty)
//   empty    : occupancy is zero
//   rd_data  : head record, read straight from storage (no path from wr_data)
module tri_record_fifo #(
  parameter int unsigned Width = 144,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic             empty,
  output logic [Width-1:0] rd_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  assign do_rd = rd_en & ~empty;
  // When full, a same-cycle read frees the head slot, which is exactly where wr_ptr points.
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);  // Depth is a power of two: natural wrap
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tri_word_assembler.sv
// Collects deserialised words into triangle records of WORDS words, buffers up to DEPTH records
// and offers them to the rasteriser over valid/ready.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   word_valid : one-cycle pulse, word_in holds a new word
//   word_in    : deserialised word
//   resync     : drop the partial record, next word is word 0 (wins over word_valid)
//   tri_valid  : head record available
//   tri_ready  : consumer takes the head when tri_valid is also high
//   tri_data   : head record, word k at bits [16k+15:16k]
//   word_idx   : next word slot to fill
//   overflow   : sticky, a completed record was dropped because the buffer was full
module tri_word_assembler
  import tri_word_assembler_pkg::*;
#(
  parameter int unsigned WORDS = TRI_WORDS_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         word_valid,
  input  tri_word_t                    word_in,
  input  logic                         resync,
  output logic                         tri_valid,
  input  logic                         tri_ready,
  output logic [rec_width(WORDS)-1:0]  tri_data,
  output logic [3:0]                   word_idx,
  output logic                         overflow
);

  localparam int unsigned RecW    = rec_width(WORDS);
  localparam int unsigned AsmW    = rec_width(WORDS - 1);
  localparam logic [3:0]  LastIdx = 4'(WORDS - 1);

  // Only slots 0..WORDS-2 are stored; the last word goes straight into the pushed record.
  logic [AsmW-1:0] asm_q, asm_d;
  logic [3:0]      idx_q, idx_d;
  logic            overflow_q, overflow_d;
  logic            push_req, push, pop;
  logic            fifo_full, fifo_empty;
  logic [RecW-1:0] record;

  assign record    = {word_in, asm_q};
  assign tri_valid = ~fifo_empty;
  assign pop       = tri_valid & tri_ready;
  assign push      = push_req & (~fifo_full | pop);
  assign word_idx  = idx_q;
  assign overflow  = overflow_q;

  always_comb begin
    asm_d      = asm_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    push_req   = 1'b0;
    if (resync) begin
      idx_d = '0;
    end else if (word_valid) begin
      if (idx_q == LastIdx) begin
        push_req = 1'b1;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + 4'd1;
        for (int unsigned k = 0; k < WORDS - 1; k++) begin
          if (idx_q == 4'(k)) begin
            asm_d[k*WORD_W +: WORD_W] = word_in;
          end
        end
      end
    end
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  tri_record_fifo #(
    .Width (RecW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (record),
    .full    (fifo_full),
    .rd_en   (pop),
    .empty   (fifo_empty),
    .rd_data (tri_data)
  );

endmodule
